// File: rtl/burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_pkg
// Purpose  : Shared burst mode / FSM state encodings and default widths for
//            the burst SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package burst_pkg;

  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_LEN_WIDTH    = 4;
  localparam int DEF_STRIDE_WIDTH = 4;

  // Burst addressing mode carried on req_mode; code 3 is reserved/illegal.
  typedef enum logic [1:0] {
    FIXED        = 2'd0,
    INCR         = 2'd1,
    WRAP         = 2'd2,
    MODE_ILLEGAL = 2'd3
  } burst_mode_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : burst_addr_gen
// Purpose  : Per-beat word address sequencer for FIXED / INCR / WRAP bursts.
//            load captures the start address and burst shape; step advances
//            to the next beat address.
// Revision : 1.0 - initial release
// ============================================================================
module burst_addr_gen
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int STRIDE_WIDTH = DEF_STRIDE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  burst_mode_t             mode,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic [ADDR_WIDTH-1:0]   addr
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_mask;
  burst_mode_t           r_mode;
  logic [ADDR_WIDTH-1:0] w_next;

  // Next beat address. For WRAP the window size is len+1 (a power of two),
  // so len itself is the mask of the in-window offset bits.
  always_comb begin
    w_next = r_addr;
    case (r_mode)
      INCR:    w_next = r_addr + r_stride;
      WRAP:    w_next = (r_addr & ~r_mask) | ((r_addr + ADDR_WIDTH'(1)) & r_mask);
      default: w_next = r_addr;
    endcase
  end

  // Capture burst shape on load, advance the current address on step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_mask   <= '0;
      r_mode   <= FIXED;
    end else if (load) begin
      r_addr   <= start_addr;
      r_stride <= ADDR_WIDTH'(stride);
      r_mask   <= ADDR_WIDTH'(len);
      r_mode   <= mode;
    end else if (step) begin
      r_addr   <= w_next;
    end
  end

  assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/burst_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : burst_sram_ctrl
// Purpose  : Burst request front end for a single-port inferred SRAM. Accepts
//            FIXED / INCR / WRAP read and write bursts, rejects illegal ones
//            with a one-cycle err_addr pulse, and streams read beats with a
//            one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module burst_sram_ctrl
  import burst_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int STRIDE_WIDTH = DEF_STRIDE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [STRIDE_WIDTH-1:0] req_stride,
  input  logic [1:0]              req_mode,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    busy,
  output logic                    err_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + STRIDE_WIDTH;
  localparam int LP1_W = LEN_WIDTH + 1;

  burst_state_t          r_state;
  burst_state_t          w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;

  logic                  w_load;
  logic                  w_step;
  logic                  w_mem_we;
  logic                  w_rd_issue;
  logic                  w_last;
  logic                  w_illegal;
  logic [SUM_W-1:0]      w_incr_end;
  logic [LP1_W-1:0]      w_len_p1;
  logic                  w_wrap_ok;
  logic [ADDR_WIDTH-1:0] w_addr;
  burst_mode_t           w_mode;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign w_mode = burst_mode_t'(req_mode);
  assign w_last = (r_cnt == r_len);

  // Request legality: INCR end address at full width (no wrap-around),
  // WRAP needs a power-of-two beat count of at least two.
  always_comb begin
    w_incr_end = SUM_W'(req_addr) + SUM_W'(req_len) * SUM_W'(req_stride);
    w_len_p1   = {1'b0, req_len} + LP1_W'(1);
    w_wrap_ok  = (req_len != '0) && ((w_len_p1 & {1'b0, req_len}) == '0);
    case (w_mode)
      FIXED:   w_illegal = 1'b0;
      INCR:    w_illegal = (w_incr_end > SUM_W'({ADDR_WIDTH{1'b1}}));
      WRAP:    w_illegal = !w_wrap_ok;
      default: w_illegal = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b1;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_mem_we    = 1'b0;
    w_rd_issue  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid && !w_illegal) begin
          w_load      = 1'b1;
          w_state_nxt = req_write ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          w_mem_we = 1'b1;
          w_step   = 1'b1;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      RD_BURST: begin
        w_rd_issue = 1'b1;
        w_step     = 1'b1;
        if (w_last) w_state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat counter runs 0..len and returns to 0 on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      r_len <= req_len;
    end else if (w_mem_we || w_rd_issue) begin
      r_cnt <= w_last ? '0 : r_cnt + LEN_WIDTH'(1);
    end
  end

  // Rejection pulse, one cycle after the offending request is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= req_valid && req_ready && w_illegal;
  end

  burst_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .STRIDE_WIDTH (STRIDE_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .step       (w_step),
    .mode       (w_mode),
    .start_addr (req_addr),
    .stride     (req_stride),
    .len        (req_len),
    .addr       (w_addr)
  );

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[w_addr] <= wr_data;
  end

  // Registered read port: data and valid appear one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_rd_issue && w_last;
      if (w_rd_issue) r_rd_data <= mem[w_addr];
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_data  = r_rd_data;
  assign err_addr = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_sram_ctrl
// Purpose  : Directed self-checking bench for burst_sram_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_sram_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [SW-1:0] req_stride;
  logic [1:0]    req_mode;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_last, busy, err_addr;
  logic [DW-1:0] rd_data;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] wdat  [16];
  logic [DW-1:0] exp_d [16];
  logic [DW-1:0] got_d [32];
  logic          got_l [32];
  int            got_n;
  int            seen;

  burst_sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_stride(req_stride), .req_mode(req_mode),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .err_addr(err_addr)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; returns sampled just after the accepting edge.
  task automatic send_req(input logic wr, input logic [1:0] mode, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, input logic [SW-1:0] stride);
    req_valid  = 1'b1;
    req_write  = wr;
    req_mode   = mode;
    req_addr   = addr;
    req_len    = len;
    req_stride = stride;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic write_burst(input string tag, input logic [1:0] mode, input logic [AW-1:0] addr,
                             input logic [LW-1:0] len, input logic [SW-1:0] stride,
                             input int gap_at, input int gap_len);
    send_req(1'b1, mode, addr, len, stride);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == gap_at) begin
        wr_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check({tag, "_stall_busy"}, 64'(busy), 64'd1);
          check({tag, "_stall_wr_ready"}, 64'(wr_ready), 64'd1);
        end
      end
      wr_valid = 1'b1;
      wr_data  = wdat[b];
      tick();
    end
    wr_valid = 1'b0;
    check({tag, "_done_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic read_burst(input logic [1:0] mode, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [SW-1:0] stride);
    send_req(1'b0, mode, addr, len, stride);
    got_n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rd_valid && got_n < 32) begin
        got_d[got_n] = rd_data;
        got_l[got_n] = rd_last;
        got_n++;
        if (rd_last) break;
      end
    end
    tick();
  endtask

  task automatic expect_read(input string tag, input int n, input logic check_data);
    check({tag, "_beats"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_n) begin
        if (check_data) check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == n - 1));
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_stride = '0; req_mode = '0; wr_valid = 1'b0; wr_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_err", 64'(err_addr), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // INCR write 0x10 stride 2, then INCR read back
    wdat[0] = 32'hA000_0000; wdat[1] = 32'hA111_1111;
    wdat[2] = 32'hA222_2222; wdat[3] = 32'hA333_3333;
    write_burst("incr_wr", 2'd1, 8'h10, 4'd3, 4'd2, -1, 0);
    exp_d[0] = 32'hA000_0000; exp_d[1] = 32'hA111_1111;
    exp_d[2] = 32'hA222_2222; exp_d[3] = 32'hA333_3333;
    read_burst(2'd1, 8'h10, 4'd3, 4'd2);
    expect_read("incr_rd", 4, 1'b1);
    // Spot checks of individual strided locations
    exp_d[0] = 32'hA111_1111;
    read_burst(2'd0, 8'h12, 4'd0, 4'd0);
    expect_read("fixed_12", 1, 1'b1);
    exp_d[0] = 32'hA333_3333;
    read_burst(2'd0, 8'h16, 4'd0, 4'd0);
    expect_read("fixed_16", 1, 1'b1);
    // INCR with stride 0 repeats the start address
    exp_d[0] = 32'hA111_1111; exp_d[1] = 32'hA111_1111;
    read_burst(2'd1, 8'h12, 4'd1, 4'd0);
    expect_read("incr_s0", 2, 1'b1);

    // WRAP: preload 0x0C..0x0F, then wrapped reads
    wdat[0] = 32'hC000_000C; wdat[1] = 32'hC000_000D;
    wdat[2] = 32'hC000_000E; wdat[3] = 32'hC000_000F;
    write_burst("wrap_pre", 2'd1, 8'h0C, 4'd3, 4'd1, -1, 0);
    exp_d[0] = 32'hC000_000D; exp_d[1] = 32'hC000_000E;
    exp_d[2] = 32'hC000_000F; exp_d[3] = 32'hC000_000C;
    read_burst(2'd2, 8'h0D, 4'd3, 4'd0);
    expect_read("wrap4", 4, 1'b1);
    exp_d[0] = 32'hC000_000F; exp_d[1] = 32'hC000_000E;
    read_burst(2'd2, 8'h0F, 4'd1, 4'd0);
    expect_read("wrap2", 2, 1'b1);

    // Illegal INCR past end of memory: rejected, no write
    wdat[0] = 32'h5A5A_F8F8;
    write_burst("pre_f8", 2'd0, 8'hF8, 4'd0, 4'd0, -1, 0);
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    send_req(1'b1, 2'd1, 8'hF8, 4'd7, 4'd2);
    check("oob_err", 64'(err_addr), 64'd1);
    check("oob_busy", 64'(busy), 64'd0);
    check("oob_wr_ready", 64'(wr_ready), 64'd0);
    tick();
    check("oob_err_pulse", 64'(err_addr), 64'd0);
    check("oob_busy2", 64'(busy), 64'd0);
    wr_valid = 1'b0;
    exp_d[0] = 32'h5A5A_F8F8;
    read_burst(2'd0, 8'hF8, 4'd0, 4'd0);
    expect_read("oob_nowrite", 1, 1'b1);

    // Reserved mode and non-power-of-two WRAP are rejected
    send_req(1'b0, 2'd3, 8'h00, 4'd0, 4'd0);
    check("mode3_err", 64'(err_addr), 64'd1);
    check("mode3_busy", 64'(busy), 64'd0);
    tick();
    send_req(1'b0, 2'd2, 8'h20, 4'd2, 4'd0);
    check("wrap3_err", 64'(err_addr), 64'd1);
    check("wrap3_busy", 64'(busy), 64'd0);
    tick();

    // INCR ending exactly at the last word is legal
    read_burst(2'd1, 8'hF1, 4'd7, 4'd2);
    expect_read("incr_edge", 8, 1'b0);

    // Stalled write: old contents 0x20..0x24, then overwrite 0x20..0x23
    wdat[0] = 32'h0B00_0000; wdat[1] = 32'h0B00_0001; wdat[2] = 32'h0B00_0002;
    wdat[3] = 32'h0B00_0003; wdat[4] = 32'h0B00_0004;
    write_burst("old20", 2'd1, 8'h20, 4'd4, 4'd1, -1, 0);
    wdat[0] = 32'hE000_0000; wdat[1] = 32'hE000_0001;
    wdat[2] = 32'hE000_0002; wdat[3] = 32'hE000_0003;
    write_burst("stall", 2'd1, 8'h20, 4'd3, 4'd1, 2, 2);
    exp_d[0] = 32'hE000_0000; exp_d[1] = 32'hE000_0001; exp_d[2] = 32'hE000_0002;
    exp_d[3] = 32'hE000_0003; exp_d[4] = 32'h0B00_0004;
    read_burst(2'd1, 8'h20, 4'd4, 4'd1);
    expect_read("stall_rd", 5, 1'b1);

    // Reset in the middle of a 16-beat read
    send_req(1'b0, 2'd1, 8'h00, 4'd15, 4'd1);
    seen = 0;
    for (int c = 0; c < 10 && seen < 3; c++) begin
      tick();
      if (rd_valid) seen++;
    end
    check("mid_pre_beats", 64'(seen), 64'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rd_last", 64'(rd_last), 64'd0);
    check("mid_rd_data", 64'(rd_data), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_req_ready", 64'(req_ready), 64'd1);
    exp_d[0] = 32'hA000_0000;
    read_burst(2'd0, 8'h10, 4'd0, 4'd3);
    expect_read("post_rst", 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
